// File: rtl/drive_assist_sequencer.sv
// drive_assist_sequencer
//   Sequences the 5-stage desired-drive multiply pipeline for the motor
//   current loop. A sample tick freezes the sensor operands onto the
//   pipeline inputs. The block then waits out the pipeline latency and
//   captures the target current. It slew-limits that target into the
//   commanded current for the PI current loop.
//
// Optional feature (macro DRIVE_SEQ_SAT_MON_EN):
//   Saturation monitor. SAT_LIMIT consecutive normal-path captures of
//   12'hFFF set a sticky sat_fault. While the fault is set, the update
//   target is forced to 0. Without the macro, sat_fault is tied low.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   sample_tick         one-cycle request to start a computation
//   *_in                sensor samples, latched on an accepted tick
//   avg_torque, cadence, incline, scale, not_pedaling
//                       held operands driving the pipeline
//   target_curr_pipe    pipeline result
//   clr_overrun         clears the sticky overrun flag
//   cmd_curr, cmd_vld   slew-limited command and its one-cycle update pulse
//   busy                state machine not IDLE
//   overrun             sticky: a tick was dropped
//   sat_fault           saturation fault (optional feature)
//
// Handshake: sample_tick is accepted only while the FSM is IDLE (busy=0).
// A tick seen while busy=1 is dropped and sets overrun. cmd_vld is a
// one-cycle strobe with no back-pressure. cmd_curr is valid in that cycle
// and holds until the next strobe.
module drive_assist_sequencer #(
  parameter int          PIPE_LAT  = 5,
  parameter logic [11:0] SLEW_UP   = 12'd64,
  parameter logic [11:0] SLEW_DN   = 12'd128,
  parameter int          SAT_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_tick,
  input  logic [11:0] avg_torque_in,
  input  logic [4:0]  cadence_in,
  input  logic [12:0] incline_in,
  input  logic [2:0]  scale_in,
  input  logic        not_pedaling_in,
  output logic [11:0] avg_torque,
  output logic [4:0]  cadence,
  output logic [12:0] incline,
  output logic [2:0]  scale,
  output logic        not_pedaling,
  input  logic [11:0] target_curr_pipe,
  input  logic        clr_overrun,
  output logic [11:0] cmd_curr,
  output logic        cmd_vld,
  output logic        busy,
  output logic        overrun,
  output logic        sat_fault
);

  localparam int CW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, UPDATE = 2'd2} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic [11:0]   target_q;
  logic [11:0]   upd_target;
  logic [12:0]   diff;
  logic [12:0]   neg_diff;
  logic [11:0]   cmd_nxt;
  logic          accept;
  logic          capture;

  assign accept  = (state == IDLE) && sample_tick;
  assign capture = (state == WAIT) && (wait_cnt == '0);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_tick) state_nxt = not_pedaling_in ? UPDATE : WAIT;
      WAIT:    if (wait_cnt == '0) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DRIVE_SEQ_SAT_MON_EN
  assign upd_target = sat_fault ? 12'd0 : target_q;
`else
  assign upd_target = target_q;
`endif

  // Unsigned operands widened by one bit, so bit 12 of the difference is
  // the sign. The magnitude of any difference fits in 12 bits.
  always_comb begin
    diff     = {1'b0, upd_target} - {1'b0, cmd_curr};
    neg_diff = 13'd0 - diff;
    cmd_nxt  = cmd_curr;
    if (!diff[12]) begin
      // Clamp to the target when within one step, so the command never wraps.
      cmd_nxt = (diff[11:0] > SLEW_UP) ? cmd_curr + SLEW_UP : upd_target;
    end else begin
      cmd_nxt = (neg_diff[11:0] > SLEW_DN) ? cmd_curr - SLEW_DN : upd_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      avg_torque   <= '0;
      cadence      <= '0;
      incline      <= '0;
      scale        <= '0;
      not_pedaling <= 1'b0;
      wait_cnt     <= '0;
      target_q     <= '0;
      cmd_curr     <= '0;
      cmd_vld      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      cmd_vld <= 1'b0;
      if (accept) begin
        avg_torque   <= avg_torque_in;
        cadence      <= cadence_in;
        incline      <= incline_in;
        scale        <= scale_in;
        not_pedaling <= not_pedaling_in;
        // The not-pedaling path skips the pipeline and commands zero.
        if (not_pedaling_in) target_q <= 12'd0;
        else                 wait_cnt <= CW'(PIPE_LAT);
      end
      if ((state == WAIT) && (wait_cnt != '0)) wait_cnt <= wait_cnt - 1'b1;
      if (capture) target_q <= target_curr_pipe;
      if (state == UPDATE) begin
        cmd_curr <= cmd_nxt;
        cmd_vld  <= 1'b1;
      end
      // A dropped tick takes priority over a clear in the same cycle.
      if (sample_tick && (state != IDLE)) overrun <= 1'b1;
      else if (clr_overrun)               overrun <= 1'b0;
    end
  end

`ifdef DRIVE_SEQ_SAT_MON_EN
  localparam int SW = $clog2(SAT_LIMIT + 1);
  logic [SW-1:0] sat_cnt;

  // Only normal-path captures move the counter. Not-pedaling sequences
  // never pass through capture, so they leave it unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_cnt   <= '0;
      sat_fault <= 1'b0;
    end else if (capture) begin
      if (target_curr_pipe == 12'hFFF) begin
        if (sat_cnt != SW'(SAT_LIMIT)) sat_cnt <= sat_cnt + 1'b1;
        if (sat_cnt == SW'(SAT_LIMIT - 1)) sat_fault <= 1'b1;
      end else begin
        sat_cnt <= '0;
      end
    end
  end
`else
  assign sat_fault = 1'b0;
`endif

endmodule

// File: tb/tb_drive_assist_sequencer.sv
// Testbench for drive_assist_sequencer. Each tick's expected command is
// computed from a small slew model and queued. It is popped when cmd_vld
// appears. Held operands, busy, latency, overrun and sat_fault are
// checked along the way.
module tb_drive_assist_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic [11:0] avg_torque_in = '0;
  logic [4:0]  cadence_in = '0;
  logic [12:0] incline_in = '0;
  logic [2:0]  scale_in = '0;
  logic        not_pedaling_in = 1'b0;
  logic [11:0] avg_torque;
  logic [4:0]  cadence;
  logic [12:0] incline;
  logic [2:0]  scale;
  logic        not_pedaling;
  logic [11:0] target_curr_pipe = '0;
  logic        clr_overrun = 1'b0;
  logic [11:0] cmd_curr;
  logic        cmd_vld;
  logic        busy;
  logic        overrun;
  logic        sat_fault;

  drive_assist_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sample_tick      (sample_tick),
    .avg_torque_in    (avg_torque_in),
    .cadence_in       (cadence_in),
    .incline_in       (incline_in),
    .scale_in         (scale_in),
    .not_pedaling_in  (not_pedaling_in),
    .avg_torque       (avg_torque),
    .cadence          (cadence),
    .incline          (incline),
    .scale            (scale),
    .not_pedaling     (not_pedaling),
    .target_curr_pipe (target_curr_pipe),
    .clr_overrun      (clr_overrun),
    .cmd_curr         (cmd_curr),
    .cmd_vld          (cmd_vld),
    .busy             (busy),
    .overrun          (overrun),
    .sat_fault        (sat_fault)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard and model state
  logic [11:0] exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          mdl_cmd = 0;
  int          mdl_sat_cnt = 0;
  logic        mdl_sat = 1'b0;
  logic [11:0] h_torque = '0;
  logic [4:0]  h_cadence = '0;
  logic [12:0] h_incline = '0;
  logic [2:0]  h_scale = '0;
  logic        h_np = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int slew(input int cur, input int tgt);
    if (tgt > cur)      return (tgt - cur > 64)  ? cur + 64  : tgt;
    else if (cur > tgt) return (cur - tgt > 128) ? cur - 128 : tgt;
    else                return cur;
  endfunction

  task automatic scramble_inputs();
    avg_torque_in = 12'($urandom_range(0, 4095));
    cadence_in    = 5'($urandom_range(0, 31));
    incline_in    = 13'($urandom_range(0, 8191));
    scale_in      = 3'($urandom_range(0, 7));
  endtask

  task automatic check_ops();
    check("hold_torque",  avg_torque,   h_torque);
    check("hold_cadence", cadence,      h_cadence);
    check("hold_incline", incline,      h_incline);
    check("hold_scale",   scale,        h_scale);
    check("hold_np",      not_pedaling, h_np);
  endtask

  // Drives an accepted tick and queues its expected command. Returns at
  // the negedge after the accepting edge E0.
  task automatic start_tick(input logic np, input logic [11:0] pipe);
    int tgt;
    @(negedge clk);
    scramble_inputs();
    not_pedaling_in  = np;
    target_curr_pipe = pipe;
    sample_tick      = 1'b1;
    h_torque  = avg_torque_in;
    h_cadence = cadence_in;
    h_incline = incline_in;
    h_scale   = scale_in;
    h_np      = np;
    if (np) begin
      tgt = 0;
    end else begin
      tgt = int'(pipe);
      if (pipe == 12'hFFF) begin
        if (mdl_sat_cnt < 4) mdl_sat_cnt++;
        if (mdl_sat_cnt == 4) mdl_sat = 1'b1;
      end else begin
        mdl_sat_cnt = 0;
      end
    end
`ifdef DRIVE_SEQ_SAT_MON_EN
    if (mdl_sat) tgt = 0;
`endif
    mdl_cmd = slew(mdl_cmd, tgt);
    exp_q.push_back(12'(mdl_cmd));
    @(negedge clk);
    sample_tick = 1'b0;
    check_ops();
    check("busy_start", busy, 1'b1);
  endtask

  // Waits (bounded) for cmd_vld. lat is the expected number of negedges
  // from the current one.
  task automatic wait_cmd(input int lat);
    int n = 0;
    logic exp_sat;
    logic [11:0] exp_cmd;
    while (cmd_vld !== 1'b1 && n < 20) begin
      check("busy_wait", busy, 1'b1);
      check_ops();
      @(negedge clk);
      scramble_inputs();
      n++;
    end
    check("latency", n, lat);
    check("vld_seen", cmd_vld, 1'b1);
    check("exp_queue_nonempty", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      exp_cmd = exp_q.pop_front();
      check("cmd_curr", cmd_curr, exp_cmd);
    end else begin
      exp_cmd = cmd_curr;
    end
    check("busy_done", busy, 1'b0);
    exp_sat = 1'b0;
`ifdef DRIVE_SEQ_SAT_MON_EN
    exp_sat = mdl_sat;
`endif
    check("sat_fault", sat_fault, exp_sat);
    @(negedge clk);
    check("vld_pulse_end", cmd_vld, 1'b0);
    check("cmd_hold", cmd_curr, exp_cmd);
  endtask

  task automatic check_reset_values();
    check("rst_busy",    busy,         1'b0);
    check("rst_cmd",     cmd_curr,     12'h000);
    check("rst_vld",     cmd_vld,      1'b0);
    check("rst_overrun", overrun,      1'b0);
    check("rst_sat",     sat_fault,    1'b0);
    check("rst_torque",  avg_torque,   12'h000);
    check("rst_cadence", cadence,      5'h00);
    check("rst_incline", incline,      13'h0000);
    check("rst_scale",   scale,        3'h0);
    check("rst_np",      not_pedaling, 1'b0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // Ramp up to 0x200 in 64-steps, then a ninth tick with diff == 0
    for (int i = 0; i < 9; i++) begin
      start_tick(1'b0, 12'h200);
      wait_cmd(7);
    end
    check("ramp_top", cmd_curr, 12'h200);

    // Not-pedaling path: short latency, ramp down to 0 without underflow
    for (int i = 0; i < 5; i++) begin
      start_tick(1'b1, 12'h200);
      wait_cmd(1);
    end
    check("ramp_bottom", cmd_curr, 12'h000);

    // Bring the command back up before the overrun checks
    start_tick(1'b0, 12'h200);
    wait_cmd(7);

    // Tick dropped at E0+3 sets overrun and leaves the operands alone
    start_tick(1'b0, 12'h200);
    @(negedge clk);
    @(negedge clk);
    scramble_inputs();
    not_pedaling_in = 1'b1;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    not_pedaling_in = 1'b0;
    check("overrun_set", overrun, 1'b1);
    check_ops();
    wait_cmd(4);
    check("overrun_sticky", overrun, 1'b1);

    // A plain clear drops the flag
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("overrun_clr", overrun, 1'b0);

    // A clear together with a dropped tick leaves it set
    start_tick(1'b0, 12'h200);
    @(negedge clk);
    sample_tick = 1'b1;
    clr_overrun = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    clr_overrun = 1'b0;
    check("overrun_clr_vs_drop", overrun, 1'b1);
    wait_cmd(5);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("overrun_clr2", overrun, 1'b0);

    // Reset at E0+4 abandons the sequence with no cmd_vld
    start_tick(1'b0, 12'h200);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("no_vld_after_rst", cmd_vld, 1'b0);
      @(negedge clk);
    end
    exp_q.delete();
    mdl_cmd     = 0;
    mdl_sat_cnt = 0;
    mdl_sat     = 1'b0;
    start_tick(1'b0, 12'h200);
    wait_cmd(7);
    check("clean_after_rst", cmd_curr, 12'h040);

    // Pipe saturated at 0xFFF: full-scale ramp, or fault and ramp-down
    for (int i = 0; i < 66; i++) begin
      start_tick(1'b0, 12'hFFF);
      wait_cmd(7);
    end
`ifdef DRIVE_SEQ_SAT_MON_EN
    check("sat_final_cmd", cmd_curr, 12'h000);
    check("sat_final_flag", sat_fault, 1'b1);
`else
    check("full_scale_cmd", cmd_curr, 12'hFFF);
    check("sat_tied_low", sat_fault, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
